// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target-side blocks.
//   i2c_state_t : target protocol state
//   I2C_ACK/I2C_NACK, I2C_RW_WRITE/I2C_RW_READ : bus-level bit meanings
//   maj3        : 3-input majority vote used by the glitch filter
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WORD,
    WORD_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } i2c_state_t;

  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// I2C bus line conditioning and event detection.
// Ports:
//   clk, rst_n       : system clock, async active-low reset
//   scl_in, sda_in   : raw sampled bus levels
//   scl, sda         : synchronized, majority-filtered levels
//   scl_rise/scl_fall: one-cycle pulses on filtered SCL edges
//   start/stop       : one-cycle pulses for START / STOP conditions
module i2c_bus_monitor
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] scl_sync, sda_sync;
  logic [1:0] scl_hist, sda_hist;
  logic       scl_prev, sda_prev;

  // Everything resets to the idle (released, high) bus level so that
  // leaving reset never fabricates an edge or a START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_hist <= '1;
      sda_hist <= '1;
      scl      <= 1'b1;
      sda      <= 1'b1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
      scl      <= maj3(scl_sync[1], scl_hist[0], scl_hist[1]);
      sda      <= maj3(sda_sync[1], sda_hist[0], sda_hist[1]);
      scl_prev <= scl;
      sda_prev <= sda;
    end
  end

  assign scl_rise = scl & ~scl_prev;
  assign scl_fall = ~scl & scl_prev;
  assign start    = scl & scl_prev & sda_prev & ~sda;
  assign stop     = scl & scl_prev & ~sda_prev & sda;

endmodule

// File: rtl/i2c_eeprom_target.sv
// I2C target emulating a small byte-addressed EEPROM.
// Ports:
//   clk, rst_n        : system clock (>= 20x SCL), async active-low reset
//   scl_in, sda_in    : sampled bus levels
//   sda_pull          : 1 = pull SDA low, 0 = release
//   wr_strobe         : one-cycle pulse when a written byte is committed
//   wr_addr, wr_data  : address/data of the committed byte
//   busy              : high from a matched address until STOP or NACK
module i2c_eeprom_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR  = 7'h50,
  parameter int unsigned MEM_DEPTH = 16,
  parameter int unsigned HOLD_CYC  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_pull,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  localparam int unsigned PW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned HW = $clog2(HOLD_CYC + 2);

  logic scl_f, sda_f, scl_rise, scl_fall, start, stop;

  i2c_bus_monitor u_mon (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .scl      (scl_f),
    .sda      (sda_f),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  i2c_state_t    state;
  logic [3:0]    bit_cnt;
  logic [7:0]    sh;
  logic [PW-1:0] ptr;
  logic          rw;
  logic [7:0]    mem [MEM_DEPTH];

  // SDA updates are requested on scl_fall and applied HOLD_CYC cycles later.
  logic          pend;
  logic          pend_pull;
  logic [HW-1:0] hold_cnt;

  logic [7:0]    rx_byte;

  always_comb begin
    rx_byte = {sh[6:0], sda_f};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      sh        <= '0;
      ptr       <= '0;
      rw        <= I2C_RW_WRITE;
      pend      <= 1'b0;
      pend_pull <= 1'b0;
      hold_cnt  <= '0;
      sda_pull  <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      wr_strobe <= 1'b0;

      if (pend) begin
        // If SCL is already high again the slot is gone; dropping the update
        // keeps SDA stable while SCL is high.
        if (scl_f) begin
          pend <= 1'b0;
        end else if (hold_cnt <= HW'(1)) begin
          sda_pull <= pend_pull;
          pend     <= 1'b0;
        end else begin
          hold_cnt <= hold_cnt - HW'(1);
        end
      end

      if (start) begin
        state    <= ADDR;
        bit_cnt  <= '0;
        sda_pull <= 1'b0;
        pend     <= 1'b0;
      end else if (stop) begin
        state    <= IDLE;
        busy     <= 1'b0;
        sda_pull <= 1'b0;
        pend     <= 1'b0;
      end else begin
        case (state)
          IDLE, IGNORE: ;

          ADDR, WORD, WR_BYTE: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              sh      <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              // A data byte is committed on the sample edge of its last bit.
              if (state == WR_BYTE && bit_cnt == 4'd7) begin
                mem[ptr]  <= rx_byte;
                wr_strobe <= 1'b1;
                wr_addr   <= 8'(ptr);
                wr_data   <= rx_byte;
                ptr       <= ptr + PW'(1);
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if (state == ADDR) begin
                if (sh[7:1] == DEV_ADDR) begin
                  state     <= ADDR_ACK;
                  busy      <= 1'b1;
                  rw        <= sh[0];
                  pend      <= 1'b1;
                  pend_pull <= 1'b1;
                  hold_cnt  <= HW'(HOLD_CYC);
                end else begin
                  state <= IGNORE;
                end
              end else begin
                if (state == WORD) begin
                  ptr   <= sh[PW-1:0];
                  state <= WORD_ACK;
                end else begin
                  state <= WR_ACK;
                end
                pend      <= 1'b1;
                pend_pull <= 1'b1;
                hold_cnt  <= HW'(HOLD_CYC);
              end
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt  <= '0;
              pend     <= 1'b1;
              hold_cnt <= HW'(HOLD_CYC);
              if (rw == I2C_RW_READ) begin
                state     <= RD_BYTE;
                sh        <= mem[ptr];
                pend_pull <= ~mem[ptr][7];
              end else begin
                state     <= WORD;
                pend_pull <= 1'b0;
              end
            end
          end

          WORD_ACK, WR_ACK: begin
            if (scl_fall) begin
              state     <= WR_BYTE;
              bit_cnt   <= '0;
              pend      <= 1'b1;
              pend_pull <= 1'b0;
              hold_cnt  <= HW'(HOLD_CYC);
            end
          end

          RD_BYTE: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              pend     <= 1'b1;
              hold_cnt <= HW'(HOLD_CYC);
              if (bit_cnt == 4'd8) begin
                state     <= RD_ACK;
                bit_cnt   <= '0;
                pend_pull <= 1'b0;
              end else begin
                sh        <= {sh[6:0], 1'b0};
                pend_pull <= ~sh[6];
              end
            end
          end

          RD_ACK: begin
            // bit_cnt==1 marks "controller ACKed, next byte starts at scl_fall".
            if (scl_rise) begin
              ptr <= ptr + PW'(1);
              if (sda_f == I2C_NACK) begin
                state    <= IGNORE;
                busy     <= 1'b0;
                sda_pull <= 1'b0;
                pend     <= 1'b0;
              end else begin
                bit_cnt <= 4'd1;
              end
            end else if (scl_fall && bit_cnt == 4'd1) begin
              state     <= RD_BYTE;
              bit_cnt   <= '0;
              sh        <= mem[ptr];
              pend      <= 1'b1;
              pend_pull <= ~mem[ptr][7];
              hold_cnt  <= HW'(HOLD_CYC);
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_target.sv
// Scoreboard bench for i2c_eeprom_target: bus tasks act as the I2C controller,
// expected ACK/read/write-commit values are queued at issue time and a
// separate monitor compares them as the DUT produces them.
module tb_i2c_eeprom_target;
  import i2c_pkg::*;

  localparam int unsigned Q = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_drv = 1'b1;
  logic       sda_drv = 1'b1;
  logic       scl_in, sda_in;
  logic       sda_pull, wr_strobe, busy;
  logic [7:0] wr_addr, wr_data;

  assign scl_in = scl_drv;
  assign sda_in = sda_drv & ~sda_pull;

  i2c_eeprom_target #(
    .DEV_ADDR  (7'h50),
    .MEM_DEPTH (16),
    .HOLD_CYC  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_pull  (sda_pull),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  string      exp_name_q[$];
  logic [7:0] exp_val_q[$];
  logic [7:0] obs_val_q[$];
  logic [15:0] exp_wr_q[$];

  logic pull_q = 1'b0;
  int   pull_hi_changes = 0;
  bit   pull_seen = 1'b0;
  bit   busy_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] w;
    logic [7:0]  o;
    if (rst_n && wr_strobe) begin
      if (exp_wr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_wr_strobe: actual addr=0x%0h data=0x%0h required none", wr_addr, wr_data);
      end else begin
        w = exp_wr_q.pop_front();
        check("wr_addr", {24'd0, wr_addr}, {24'd0, w[15:8]});
        check("wr_data", {24'd0, wr_data}, {24'd0, w[7:0]});
      end
    end
    while (obs_val_q.size() > 0) begin
      o = obs_val_q.pop_front();
      if (exp_val_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_observation: actual=0x%0h required none", o);
      end else begin
        check(exp_name_q.pop_front(), {24'd0, o}, {24'd0, exp_val_q.pop_front()});
      end
    end
    if (rst_n && sda_pull !== pull_q && scl_drv) pull_hi_changes++;
    pull_q = sda_pull;
    if (sda_pull) pull_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1; wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q);
    sda_drv = 1'b0; wait_clk(Q);
    scl_drv = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q);
    sda_drv = 1'b1; wait_clk(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_drv = b;    wait_clk(Q);
    scl_drv = 1'b1; wait_clk(2 * Q);
    scl_drv = 1'b0; wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_drv = 1'b1; wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q);
    b = sda_in;     wait_clk(Q);
    scl_drv = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input string name, input logic [7:0] data, input logic exp_ack);
    logic ack;
    exp_name_q.push_back({name, "_ack"});
    exp_val_q.push_back({7'd0, exp_ack});
    for (int i = 7; i >= 0; i--) write_bit(data[i]);
    read_bit(ack);
    obs_val_q.push_back({7'd0, ack});
  endtask

  task automatic read_byte(input string name, input logic [7:0] exp_data, input logic send_ack);
    logic [7:0] d;
    logic       b;
    exp_name_q.push_back(name);
    exp_val_q.push_back(exp_data);
    d = '0;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    obs_val_q.push_back(d);
    write_bit(send_ack);
  endtask

  task automatic rand_read(input string name, input logic [7:0] addr, input logic [7:0] exp_data);
    i2c_start();
    write_byte({name, "_dw"}, 8'hA0, I2C_ACK);
    write_byte({name, "_wa"}, addr, I2C_ACK);
    i2c_start();
    write_byte({name, "_dr"}, 8'hA1, I2C_ACK);
    read_byte(name, exp_data, I2C_NACK);
    i2c_stop();
  endtask

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit got_pull;

    wait_clk(3);
    check("rst_sda_pull", {31'd0, sda_pull}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
    check("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    rst_n = 1'b1;
    wait_clk(10);

    // Random write 0x5A to 0x03
    i2c_start();
    write_byte("w1_dev", 8'hA0, I2C_ACK);
    check("busy_after_addr", {31'd0, busy}, 32'd1);
    write_byte("w1_word", 8'h03, I2C_ACK);
    exp_wr_q.push_back({8'h03, 8'h5A});
    write_byte("w1_data", 8'h5A, I2C_ACK);
    i2c_stop();
    wait_clk(10);
    check("busy_after_stop", {31'd0, busy}, 32'd0);

    // Random read of 0x03; busy must fall on the NACK, before STOP
    i2c_start();
    write_byte("r1_dw", 8'hA0, I2C_ACK);
    write_byte("r1_wa", 8'h03, I2C_ACK);
    i2c_start();
    write_byte("r1_dr", 8'hA1, I2C_ACK);
    read_byte("r1_data", 8'h5A, I2C_NACK);
    check("busy_after_nack", {31'd0, busy}, 32'd0);
    i2c_stop();

    // Sequential write across the wrap point, then sequential read back
    i2c_start();
    write_byte("w2_dev", 8'hA0, I2C_ACK);
    write_byte("w2_word", 8'h0F, I2C_ACK);
    exp_wr_q.push_back({8'h0F, 8'h11});
    exp_wr_q.push_back({8'h00, 8'h22});
    write_byte("w2_d0", 8'h11, I2C_ACK);
    write_byte("w2_d1", 8'h22, I2C_ACK);
    i2c_stop();
    i2c_start();
    write_byte("r2_dw", 8'hA0, I2C_ACK);
    write_byte("r2_wa", 8'h0F, I2C_ACK);
    i2c_start();
    write_byte("r2_dr", 8'hA1, I2C_ACK);
    read_byte("r2_d15", 8'h11, I2C_ACK);
    read_byte("r2_d0", 8'h22, I2C_NACK);
    i2c_stop();

    // Address mismatch and general call: never acknowledged, never busy
    wait_clk(10);
    pull_seen = 1'b0;
    busy_seen = 1'b0;
    i2c_start();
    write_byte("mis_dev", 8'hA2, I2C_NACK);
    i2c_stop();
    i2c_start();
    write_byte("gc_dev", 8'h00, I2C_NACK);
    i2c_stop();
    check("mismatch_pull_seen", {31'd0, pull_seen}, 32'd0);
    check("mismatch_busy_seen", {31'd0, busy_seen}, 32'd0);

    // Abort mid-byte: old value survives; pointer from the word address stays
    i2c_start();
    write_byte("w3_dev", 8'hA0, I2C_ACK);
    write_byte("w3_word", 8'h05, I2C_ACK);
    exp_wr_q.push_back({8'h05, 8'h77});
    write_byte("w3_data", 8'h77, I2C_ACK);
    i2c_stop();
    i2c_start();
    write_byte("ab_dev", 8'hA0, I2C_ACK);
    write_byte("ab_word", 8'h05, I2C_ACK);
    write_bit(1'b1); write_bit(1'b1); write_bit(1'b0); write_bit(1'b0);
    i2c_stop();
    i2c_start();
    write_byte("ab_cur_dr", 8'hA1, I2C_ACK);
    read_byte("ab_cur_data", 8'h77, I2C_NACK);
    i2c_stop();
    // STOP right after the word-address ACK, then current-address read
    i2c_start();
    write_byte("wo_dev", 8'hA0, I2C_ACK);
    write_byte("wo_word", 8'h05, I2C_ACK);
    i2c_stop();
    i2c_start();
    write_byte("wo_cur_dr", 8'hA1, I2C_ACK);
    read_byte("wo_cur_data", 8'h77, I2C_NACK);
    i2c_stop();

    // Reset while driving a 0 bit of a read byte (array[0]=0x22, MSB 0)
    i2c_start();
    write_byte("rs_dw", 8'hA0, I2C_ACK);
    write_byte("rs_wa", 8'h00, I2C_ACK);
    i2c_start();
    write_byte("rs_dr", 8'hA1, I2C_ACK);
    got_pull = 1'b0;
    for (int i = 0; i < 4 * Q; i++) begin
      if (sda_pull === 1'b1) begin
        got_pull = 1'b1;
        break;
      end
      wait_clk(1);
    end
    check("rd_drive_before_reset", {31'd0, got_pull}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_sda_pull", {31'd0, sda_pull}, 32'd0);
    check("rst_async_busy", {31'd0, busy}, 32'd0);
    sda_drv = 1'b1;
    wait_clk(5);
    rst_n = 1'b1;
    scl_drv = 1'b1;
    wait_clk(Q);

    i2c_start();
    write_byte("w4_dev", 8'hA0, I2C_ACK);
    write_byte("w4_word", 8'h09, I2C_ACK);
    exp_wr_q.push_back({8'h09, 8'hA5});
    write_byte("w4_data", 8'hA5, I2C_ACK);
    i2c_stop();
    rand_read("r4_cleared", 8'h03, 8'h00);
    rand_read("r4_data", 8'h09, 8'hA5);

    wait_clk(10);
    check("exp_q_drained", exp_val_q.size(), 32'd0);
    check("obs_q_drained", obs_val_q.size(), 32'd0);
    check("exp_wr_drained", exp_wr_q.size(), 32'd0);
    check("sda_change_while_scl_high", pull_hi_changes, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
